gshare_predictor: RTL

Global-history branch predictor that produces the `global_prediction` bit consumed by the tournament chooser. It sits beside the fetch stage: it reads a pattern history table (PHT) of 2-bit saturating counters indexed by PC XOR global history. It is trained from EX with the resolved outcome of each conditional branch. The PHT index travels down the pipeline with the instruction, so the EX-stage update writes the same entry that made the prediction.

---
 rtl/gshare_predictor_pkg.sv | 37 +++
 rtl/gshare_predictor_pht_array.sv | 56 +++++
 rtl/gshare_predictor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor_pkg
// Description : Shared RV32I pipeline types plus the gshare predictor's
//               2-bit counter encodings and INIT/RUN state enumeration.
//               Contents:
//                 rv32i_word          - 32-bit machine word
//                 rv32i_control_word  - decoded control bundle (EX stage)
//                 SNT/WNT/WT/ST       - saturating counter encodings
//                 gshare_state_e      - predictor state (INIT, RUN)
// Revision    : 1.0 - initial release
// ============================================================================
package gshare_predictor_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } rv32i_control_word;

    // 2-bit saturating counter encodings; MSB is the taken prediction.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } gshare_state_e;

endpackage
`default_nettype wire

// File: rtl/gshare_predictor_pht_array.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor_pht_array
// Description : Pattern history table, 2^PHT_INDEX entries of 2-bit counters.
//               The contents are not reset; the owner sweeps every entry to
//               WNT through the init port instead.
//               Ports:
//                 clk          - clock, writes on rising edge
//                 init_en      - sweep write enable (has priority)
//                 init_ptr     - sweep write address (data is WNT)
//                 wr_en        - training write enable
//                 wr_idx       - training write address
//                 wr_data      - training write data
//                 rd_idx       - prediction read address (async)
//                 rd_data      - prediction read data
//                 upd_rd_idx   - training read address (async)
//                 upd_rd_data  - training read data (read-modify-write)
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor_pht_array
    import gshare_predictor_pkg::*;
#(
    parameter int PHT_INDEX = 8
) (
    input  logic                 clk,
    input  logic                 init_en,
    input  logic [PHT_INDEX-1:0] init_ptr,
    input  logic                 wr_en,
    input  logic [PHT_INDEX-1:0] wr_idx,
    input  logic [1:0]           wr_data,
    input  logic [PHT_INDEX-1:0] rd_idx,
    output logic [1:0]           rd_data,
    input  logic [PHT_INDEX-1:0] upd_rd_idx,
    output logic [1:0]           upd_rd_data
);

    localparam int c_ENTRIES = 1 << PHT_INDEX;

    logic [1:0] r_mem [c_ENTRIES];

    // The sweep owns the write port during INIT; the owner never raises
    // wr_en then, but the priority keeps the sweep authoritative regardless.
    always_ff @(posedge clk) begin
        if (init_en) begin
            r_mem[init_ptr] <= WNT;
        end else if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // Asynchronous reads: a same-cycle write is seen only after the edge.
    assign rd_data     = r_mem[rd_idx];
    assign upd_rd_data = r_mem[upd_rd_idx];

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare global-history branch predictor. Indexes a PHT of
//               2-bit counters with PC[PHT_INDEX+1:2] XOR the global history
//               and trains the entry that made the prediction once the
//               branch resolves in EX. History is non-speculative.
//               Parameters:
//                 GHR_BITS  - history width (must not exceed PHT_INDEX)
//                 PHT_INDEX - PHT address width
//               Ports:
//                 clk, rst          - clock, synchronous active-high reset
//                 if_pc             - PC of the instruction in IF
//                 global_prediction - predicted taken (0 until ready)
//                 pred_index        - PHT index used for this prediction
//                 ex_index          - pred_index carried with the EX instr
//                 ex_valid          - EX holds a live instruction
//                 idex_controlw     - EX control word (.branch used)
//                 br_en             - resolved branch outcome
//                 ready             - PHT initialisation complete
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int GHR_BITS  = 8,
    parameter int PHT_INDEX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  rv32i_word            if_pc,
    output logic                 global_prediction,
    output logic [PHT_INDEX-1:0] pred_index,
    input  logic [PHT_INDEX-1:0] ex_index,
    input  logic                 ex_valid,
    input  rv32i_control_word    idex_controlw,
    input  logic                 br_en,
    output logic                 ready
);

    localparam logic [PHT_INDEX-1:0] c_LAST_ENTRY = '1;

    gshare_state_e          r_state;
    gshare_state_e          w_state_next;
    logic [PHT_INDEX-1:0]   r_init_ptr;
    logic [GHR_BITS-1:0]    r_ghr;
    logic [PHT_INDEX-1:0]   w_ghr_ext;
    logic                   w_update;
    logic                   w_init_en;
    logic [1:0]             w_rd_ctr;
    logic [1:0]             w_ex_ctr;
    logic [1:0]             w_ctr_next;
    logic                   w_unused_bits;

    // ------------------------------------------------------------------
    // INIT/RUN state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT: begin
                // The cycle writing the last entry hands over to RUN.
                if (r_init_ptr == c_LAST_ENTRY) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    // Sweep pointer: held at 0 while rst is asserted so the sweep always
    // restarts from the first entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_ptr <= '0;
        end else if (r_state == INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
        end
    end

    assign ready     = (r_state == RUN);
    assign w_init_en = (r_state == INIT);

    // Training only fires for live conditional branches once the table is
    // initialised; jumps and INIT-time resolutions are dropped.
    assign w_update = ex_valid & idex_controlw.branch & (r_state == RUN);

    // ------------------------------------------------------------------
    // Global history register (shift in resolved outcome at EX)
    // ------------------------------------------------------------------
    generate
        if (GHR_BITS > 1) begin : g_ghr_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (w_update) begin
                    r_ghr <= {r_ghr[GHR_BITS-2:0], br_en};
                end
            end
        end else begin : g_ghr_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (w_update) begin
                    r_ghr <= br_en;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Index hash: history is zero-padded on the MSB side
    // ------------------------------------------------------------------
    assign w_ghr_ext  = PHT_INDEX'(r_ghr);
    assign pred_index = if_pc[PHT_INDEX+1:2] ^ w_ghr_ext;

    // ------------------------------------------------------------------
    // Saturating counter update for the entry that made the prediction
    // ------------------------------------------------------------------
    always_comb begin
        w_ctr_next = w_ex_ctr;
        if (br_en) begin
            if (w_ex_ctr != ST) begin
                w_ctr_next = w_ex_ctr + 2'd1;
            end
        end else begin
            if (w_ex_ctr != SNT) begin
                w_ctr_next = w_ex_ctr - 2'd1;
            end
        end
    end

    gshare_predictor_pht_array #(
        .PHT_INDEX (PHT_INDEX)
    ) u_pht (
        .clk         (clk),
        .init_en     (w_init_en),
        .init_ptr    (r_init_ptr),
        .wr_en       (w_update),
        .wr_idx      (ex_index),
        .wr_data     (w_ctr_next),
        .rd_idx      (pred_index),
        .rd_data     (w_rd_ctr),
        .upd_rd_idx  (ex_index),
        .upd_rd_data (w_ex_ctr)
    );

    // Counter contents are meaningless until the sweep finishes.
    assign global_prediction = ready & w_rd_ctr[1];

    // PC bits outside the index slice and the other control fields are
    // intentionally ignored by this block.
    assign w_unused_bits = ^{if_pc, idex_controlw};

endmodule
`default_nettype wire
